program_slot_controller: RTL

- Schedules which of the NUM_SLOTS resident programs the MIPS core executes.
- Instruction memory is split into fixed regions of SLOT_WORDS addresses: slot k starts at k*SLOT_WORDS.
- On a debounced user request it performs a context switch: halt the core, save the outgoing slot's PC, load the incoming slot's saved PC, release the core.
- Drives the 7-segment digit for the active slot and flags PC escapes from the active region.

---
 rtl/program_slot_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/program_slot_controller.sv
// Schedules one of four resident programs: debounced slot select, halt/save/load/release
// context switch, active-slot 7-segment digit and a sticky PC region fault.
// Defining PROGRAM_SLOT_TIMESLICE_EN adds round-robin switching every QUANTUM RUN cycles.
module program_slot_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int SLOT_WORDS      = 512,
  parameter int NUM_SLOTS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUANTUM         = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            select_in,
  input  logic                  select_go,
  input  logic [ADDR_WIDTH-1:0] cpu_pc,
  input  logic                  cpu_halted,
  output logic                  halt_req,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [1:0]            active_slot,
  output logic                  busy,
  output logic                  fault,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g
);

  localparam int                    DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] SLOT_SIZE = ADDR_WIDTH'(SLOT_WORDS);
  localparam logic [1:0]            LAST_SLOT = 2'(NUM_SLOTS - 1);

  if (NUM_SLOTS != 4 || SLOT_WORDS < 1 || (SLOT_WORDS & (SLOT_WORDS - 1)) != 0 ||
      DEBOUNCE_CYCLES < 1 || QUANTUM < 2) begin : g_bad_config
    $error("program_slot_controller: unsupported parameter set");
  end

  typedef enum logic [2:0] {RUN, HALT_WAIT, SAVE, LOAD, RELEASE} state_t;

  state_t                state_reg;
  logic [1:0]            target_reg;
  logic [6:0]            seg_reg;
  logic [ADDR_WIDTH-1:0] saved_pc_reg [NUM_SLOTS];

  logic                  sync1_reg, sync2_reg, level_reg, go_reg;
  logic [DB_W-1:0]       db_cnt_reg;

  logic                  switch_req;
  logic [1:0]            switch_target;
  logic [ADDR_WIDTH-1:0] region_lo, region_hi;
  logic                  pc_out;

  function automatic logic [6:0] seg_decode(input logic [1:0] s);
    case (s)
      2'd0:    return 7'b0000001;
      2'd1:    return 7'b1001111;
      2'd2:    return 7'b0010010;
      default: return 7'b0000110;
    endcase
  endfunction

  // Level filter: the synchronized button must disagree with the filtered level for
  // DEBOUNCE_CYCLES samples in a row before the level follows; rising updates emit go.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      level_reg  <= 1'b0;
      go_reg     <= 1'b0;
      db_cnt_reg <= '0;
    end else begin
      sync1_reg <= select_go;
      sync2_reg <= sync1_reg;
      go_reg    <= 1'b0;
      if (sync2_reg == level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_reg  <= sync2_reg;
        db_cnt_reg <= '0;
        go_reg     <= sync2_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

`ifdef PROGRAM_SLOT_TIMESLICE_EN
  localparam int QW = $clog2(QUANTUM);
  logic [QW-1:0] quantum_reg;
  logic          expire;

  assign expire = (state_reg == RUN) && (quantum_reg == QW'(QUANTUM - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quantum_reg <= '0;
    end else if (state_reg == LOAD || expire) begin
      quantum_reg <= '0;
    end else if (state_reg == RUN) begin
      quantum_reg <= quantum_reg + QW'(1);
    end
  end
`endif

  // A manual press always takes priority; a same-slot press swallows a coincident expiry.
  always_comb begin
    switch_req    = 1'b0;
    switch_target = select_in;
    if (go_reg) begin
      switch_req = (select_in != active_slot);
    end
`ifdef PROGRAM_SLOT_TIMESLICE_EN
    else if (expire) begin
      switch_req    = 1'b1;
      switch_target = active_slot + 2'd1;
    end
`endif
  end

  always_comb begin
    region_lo = ADDR_WIDTH'(active_slot) * SLOT_SIZE;
    region_hi = region_lo + SLOT_SIZE;
    pc_out    = (cpu_pc < region_lo) || ((active_slot != LAST_SLOT) && (cpu_pc >= region_hi));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      target_reg    <= 2'd0;
      active_slot   <= 2'd0;
      halt_req      <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_value <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      seg_reg       <= seg_decode(2'd0);
      for (int k = 0; k < NUM_SLOTS; k++) begin
        saved_pc_reg[k] <= ADDR_WIDTH'(k) * SLOT_SIZE;
      end
    end else begin
      pc_load <= 1'b0;
      case (state_reg)
        RUN: begin
          if (pc_out) begin
            fault <= 1'b1;
          end
          if (switch_req) begin
            target_reg <= switch_target;
            halt_req   <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= HALT_WAIT;
          end
        end
        HALT_WAIT: begin
          if (cpu_halted) begin
            state_reg <= SAVE;
          end
        end
        SAVE: begin
          // target never equals active_slot, so this read cannot see the write below
          saved_pc_reg[active_slot] <= cpu_pc;
          pc_load_value             <= saved_pc_reg[target_reg];
          pc_load                   <= 1'b1;
          state_reg                 <= LOAD;
        end
        LOAD: begin
          active_slot <= target_reg;
          seg_reg     <= seg_decode(target_reg);
          fault       <= 1'b0;
          halt_req    <= 1'b0;
          state_reg   <= RELEASE;
        end
        RELEASE: begin
          if (!cpu_halted) begin
            busy      <= 1'b0;
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign {a, b, c, d, e, f, g} = seg_reg;

endmodule
